// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: shared widths, timeout default and FSM encoding for the MEM stage
package mem_access_stage_pkg;
  localparam int DATA_W      = 16;
  localparam int REG_W       = 3;
  localparam int TIMEOUT_DEF = 15;
  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;
endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register with bubble and data load controls
// Ports: clk/rst, i_load_bubble (zero all fields, wins), i_load_data (capture i_*),
//        o_reg_write / o_write_reg / o_write_data (registered WB fields; hold when no load)
module mem_wb_reg
  import mem_access_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load_bubble,
  input  logic              i_load_data,
  input  logic              i_reg_write,
  input  logic [REG_W-1:0]  i_write_reg,
  input  logic [DATA_W-1:0] i_write_data,
  output logic              o_reg_write,
  output logic [REG_W-1:0]  o_write_reg,
  output logic [DATA_W-1:0] o_write_data
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst || i_load_bubble) begin
      o_reg_write  <= 1'b0;
      o_write_reg  <= '0;
      o_write_data <= '0;
    end else if (i_load_data) begin
      o_reg_write  <= i_reg_write;
      o_write_reg  <= i_write_reg;
      o_write_data <= i_write_data;
    end
  end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage driving a ready-handshake data memory with timeout
// Ports: clk/rst; mem_* EX/MEM instruction fields; dmem_* memory handshake;
//        mem_stall (hold upstream), mem_fault (timeout pulse); wb_* registered MEM/WB outputs
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_reg_write,
  input  logic              mem_mem_read,
  input  logic              mem_mem_write,
  input  logic              mem_mem_to_reg,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_write_data,
  input  logic [REG_W-1:0]  mem_write_reg,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic              mem_stall,
  output logic              mem_fault,
  output logic              wb_reg_write,
  output logic [REG_W-1:0]  wb_write_reg,
  output logic [DATA_W-1:0] wb_write_data
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t            r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_addr, r_wdata;
  logic              r_we, r_rd, r_reg_write, r_mem_to_reg;
  logic [REG_W-1:0]  r_write_reg;
  logic              w_busy, w_access, w_timeout, w_done;
  logic              w_load_bubble, w_load_data, w_wb_reg_write;
  logic [REG_W-1:0]  w_wb_write_reg;
  logic [DATA_W-1:0] w_wb_write_data;
  assign w_busy    = (r_state == ST_BUSY);
  assign w_access  = mem_mem_read | mem_mem_write;
  assign w_done    = w_busy & dmem_ready;
  assign w_timeout = w_busy & ~dmem_ready & (r_cnt == CW'(TIMEOUT - 1));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = w_busy ? ((dmem_ready | w_timeout) ? ST_IDLE : ST_BUSY)
                    : (w_access ? ST_BUSY : ST_IDLE);
  end
  // A write wins over a simultaneous read, so the read flag is masked at capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_rd         <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_write_reg  <= '0;
    end else if (!w_busy && w_access) begin
      r_cnt        <= '0;
      r_addr       <= mem_alu_result;
      r_wdata      <= mem_write_data;
      r_we         <= mem_mem_write;
      r_rd         <= mem_mem_read & ~mem_mem_write;
      r_reg_write  <= mem_reg_write;
      r_mem_to_reg <= mem_mem_to_reg;
      r_write_reg  <= mem_write_reg;
    end else if (w_busy && !dmem_ready) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end
  always_comb begin
    dmem_req        = w_busy;
    dmem_we         = w_busy & r_we;
    dmem_addr       = w_busy ? r_addr : '0;
    dmem_wdata      = w_busy ? r_wdata : '0;
    mem_stall       = (~w_busy & w_access) | (w_busy & ~dmem_ready & ~w_timeout);
    mem_fault       = w_timeout;
    w_load_bubble   = mem_stall | w_timeout;
    w_load_data     = (~w_busy & ~w_access) | w_done;
    w_wb_reg_write  = w_busy ? r_reg_write : mem_reg_write;
    w_wb_write_reg  = w_busy ? r_write_reg : mem_write_reg;
    w_wb_write_data = w_busy ? ((r_mem_to_reg & r_rd) ? dmem_rdata : r_addr) : mem_alu_result;
  end
  mem_wb_reg u_mem_wb_reg (
    .clk          (clk),
    .rst          (rst),
    .i_load_bubble(w_load_bubble),
    .i_load_data  (w_load_data),
    .i_reg_write  (w_wb_reg_write),
    .i_write_reg  (w_wb_write_reg),
    .i_write_data (w_wb_write_data),
    .o_reg_write  (wb_reg_write),
    .o_write_reg  (wb_write_reg),
    .o_write_data (wb_write_data)
  );
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed self-checking bench for mem_access_stage
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_reg_write = 1'b0, mem_mem_read = 1'b0, mem_mem_write = 1'b0, mem_mem_to_reg = 1'b0;
  logic [15:0] mem_alu_result = '0, mem_write_data = '0;
  logic [2:0]  mem_write_reg = '0;
  logic        dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata;
  logic [15:0] dmem_rdata = '0;
  logic        dmem_ready = 1'b0;
  logic        mem_stall, mem_fault, wb_reg_write;
  logic [2:0]  wb_write_reg;
  logic [15:0] wb_write_data;
  int          checks = 0;
  int          errors = 0;
  mem_access_stage dut (
    .clk(clk), .rst(rst),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg),
    .mem_alu_result(mem_alu_result), .mem_write_data(mem_write_data),
    .mem_write_reg(mem_write_reg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .mem_stall(mem_stall), .mem_fault(mem_fault),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic instr(input logic rw, input logic rd, input logic wr, input logic m2r,
                       input logic [15:0] alu, input logic [15:0] wd, input logic [2:0] wreg);
    mem_reg_write  = rw;
    mem_mem_read   = rd;
    mem_mem_write  = wr;
    mem_mem_to_reg = m2r;
    mem_alu_result = alu;
    mem_write_data = wd;
    mem_write_reg  = wreg;
  endtask
  task automatic nop;
    instr(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
  endtask
  initial begin
    step;
    step;
    check("rst_req", 16'(dmem_req), 16'd0);
    check("rst_fault", 16'(mem_fault), 16'd0);
    check("rst_wb_rw", 16'(wb_reg_write), 16'd0);
    check("rst_wb_data", wb_write_data, 16'h0000);
    rst = 1'b0;
    step;
    // ALU pass-through
    instr(1'b1, 1'b0, 1'b0, 1'b0, 16'hABCD, 16'h0000, 3'd5);
    #1 check("alu_stall_pre", 16'(mem_stall), 16'd0);
    step;
    check("alu_wb_data", wb_write_data, 16'hABCD);
    check("alu_wb_reg", 16'(wb_write_reg), 16'd5);
    check("alu_wb_rw", 16'(wb_reg_write), 16'd1);
    check("alu_stall_post", 16'(mem_stall), 16'd0);
    nop;
    step;
    check("nop_wb_rw", 16'(wb_reg_write), 16'd0);
    // Load with ready on the 3rd BUSY cycle
    instr(1'b1, 1'b1, 1'b0, 1'b1, 16'h0040, 16'h0000, 3'd3);
    dmem_rdata = 16'h1234;
    #1;
    check("ld_stall0", 16'(mem_stall), 16'd1);
    check("ld_req_idle", 16'(dmem_req), 16'd0);
    step;
    check("ld_req_b1", 16'(dmem_req), 16'd1);
    check("ld_addr_b1", dmem_addr, 16'h0040);
    check("ld_we_b1", 16'(dmem_we), 16'd0);
    check("ld_stall_b1", 16'(mem_stall), 16'd1);
    check("ld_bubble_b1", 16'(wb_reg_write), 16'd0);
    step;
    check("ld_addr_b2", dmem_addr, 16'h0040);
    check("ld_stall_b2", 16'(mem_stall), 16'd1);
    dmem_ready = 1'b1;
    #1;
    check("ld_addr_b3", dmem_addr, 16'h0040);
    check("ld_stall_b3", 16'(mem_stall), 16'd0);
    step;
    nop;
    dmem_ready = 1'b0;
    #1;
    check("ld_wb_data", wb_write_data, 16'h1234);
    check("ld_wb_rw", 16'(wb_reg_write), 16'd1);
    check("ld_wb_reg", 16'(wb_write_reg), 16'd3);
    check("ld_req_done", 16'(dmem_req), 16'd0);
    // Store with immediate ready; ready already high in IDLE is ignored
    instr(1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h5A5A, 3'd0);
    dmem_ready = 1'b1;
    #1;
    check("st_we_idle", 16'(dmem_we), 16'd0);
    check("st_stall_idle", 16'(mem_stall), 16'd1);
    step;
    check("st_we_b1", 16'(dmem_we), 16'd1);
    check("st_wdata_b1", dmem_wdata, 16'h5A5A);
    check("st_addr_b1", dmem_addr, 16'h0010);
    check("st_stall_b1", 16'(mem_stall), 16'd0);
    step;
    nop;
    dmem_ready = 1'b0;
    #1;
    check("st_we_after", 16'(dmem_we), 16'd0);
    check("st_wdata_after", dmem_wdata, 16'h0000);
    check("st_wb_rw", 16'(wb_reg_write), 16'd0);
    check("st_wb_data", wb_write_data, 16'h0010);
    // Timeout: fault only in the 15th BUSY cycle
    instr(1'b1, 1'b1, 1'b0, 1'b1, 16'h0080, 16'h0000, 3'd2);
    step;
    for (int i = 1; i < 15; i++) begin
      check("to_fault_early", 16'(mem_fault), 16'd0);
      check("to_stall_early", 16'(mem_stall), 16'd1);
      check("to_req_early", 16'(dmem_req), 16'd1);
      step;
    end
    check("to_fault", 16'(mem_fault), 16'd1);
    check("to_stall", 16'(mem_stall), 16'd0);
    nop;
    step;
    check("to_fault_gone", 16'(mem_fault), 16'd0);
    check("to_req_idle", 16'(dmem_req), 16'd0);
    check("to_wb_rw", 16'(wb_reg_write), 16'd0);
    check("to_wb_data", wb_write_data, 16'h0000);
    // Ready pulse while IDLE causes no state change
    dmem_ready = 1'b1;
    step;
    dmem_ready = 1'b0;
    #1;
    check("idle_rdy_req", 16'(dmem_req), 16'd0);
    check("idle_rdy_stall", 16'(mem_stall), 16'd0);
    // Read and write together: write wins
    instr(1'b0, 1'b1, 1'b1, 1'b0, 16'h0020, 16'hBEEF, 3'd0);
    dmem_rdata = 16'h1111;
    step;
    check("rw_we", 16'(dmem_we), 16'd1);
    check("rw_wdata", dmem_wdata, 16'hBEEF);
    dmem_ready = 1'b1;
    step;
    nop;
    dmem_ready = 1'b0;
    #1;
    check("rw_req_done", 16'(dmem_req), 16'd0);
    check("rw_wb_data", wb_write_data, 16'h0020);
    // Reset asserted mid-BUSY after WB was loaded with real data
    instr(1'b1, 1'b0, 1'b0, 1'b0, 16'h7777, 16'h0000, 3'd6);
    step;
    check("pre_rst_wb", wb_write_data, 16'h7777);
    instr(1'b1, 1'b1, 1'b0, 1'b1, 16'h0050, 16'h0000, 3'd4);
    step;
    step;
    check("pre_rst_req", 16'(dmem_req), 16'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_req", 16'(dmem_req), 16'd0);
    check("rst_mid_fault", 16'(mem_fault), 16'd0);
    check("rst_mid_wb_rw", 16'(wb_reg_write), 16'd0);
    check("rst_mid_wb_reg", 16'(wb_write_reg), 16'd0);
    check("rst_mid_wb_data", wb_write_data, 16'h0000);
    step;
    rst = 1'b0;
    instr(1'b1, 1'b0, 1'b0, 1'b0, 16'h4321, 16'h0000, 3'd1);
    step;
    check("resume_req", 16'(dmem_req), 16'd0);
    check("resume_wb_data", wb_write_data, 16'h4321);
    check("resume_wb_reg", 16'(wb_write_reg), 16'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have inputs mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg  1 bit each  control from the EX/MEM register.
REQ-004 SHALL have inputs mem_alu_result  16 (address / ALU value), mem_write_data  16 (store data), mem_write_reg  3 (destination register).
REQ-005 SHALL have outputs dmem_req  1, dmem_we  1, dmem_addr  16, dmem_wdata  16, plus inputs dmem_rdata  16 and dmem_ready  1, forming the data-memory handshake.
REQ-006 SHALL have output mem_stall  1  (hold EX/MEM and earlier stages) and output mem_fault  1  (one-cycle timeout pulse).
REQ-007 SHALL have registered outputs wb_reg_write  1, wb_write_reg  3, wb_write_data  16  (MEM/WB register contents).
REQ-008 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of BUSY cycles to wait for dmem_ready.

Function
REQ-009 SHALL define an access as mem_mem_read | mem_mem_write; when both are set, a write SHALL be performed and the read SHALL be ignored.
REQ-010 SHALL implement FSM states IDLE and BUSY.
REQ-011 IDLE with an access SHALL go to BUSY on the next edge and SHALL latch addr, wdata, we, reg_write, mem_to_reg and write_reg.
REQ-012 In BUSY, dmem_req SHALL be 1 and dmem_addr/dmem_wdata/dmem_we SHALL be driven from latched values. In IDLE, all dmem_* outputs SHALL be 0.
REQ-013 mem_stall SHALL be combinational: (IDLE & access) | (BUSY & ~dmem_ready & ~timeout).
REQ-014 BUSY with dmem_ready=1 SHALL return to IDLE on the next edge.
REQ-015 On the REQ-014 edge, the WB outputs SHALL load as follows:
- wb_write_data = dmem_rdata when the latched mem_to_reg and read were set, otherwise the latched alu_result.
- wb_reg_write = latched reg_write.
- wb_write_reg = latched write_reg.
REQ-016 A non-access instruction in IDLE SHALL load the WB outputs on the next edge with 1-cycle latency:
- wb_write_data = mem_alu_result.
- wb_reg_write = mem_reg_write.
- wb_write_reg = mem_write_reg.
REQ-017 On every stalled edge (mem_stall=1), the WB outputs SHALL load a bubble (all zero).
REQ-018 A wait counter SHALL clear on entry to BUSY and increment on each BUSY cycle without dmem_ready. The timeout condition is counter == TIMEOUT-1 with dmem_ready=0.
REQ-019 On timeout:
- The FSM SHALL go to IDLE.
- mem_fault SHALL be 1 for exactly that cycle.
- mem_stall SHALL be 0.
- The WB outputs SHALL load a bubble, so the instruction retires with no register write.
REQ-020 dmem_ready asserted while in IDLE SHALL be ignored.
REQ-021 dmem_ready=1 in the first BUSY cycle SHALL complete the access, giving a minimum access latency of 2 cycles from the instruction arriving to WB load.
REQ-022 Back-to-back accesses SHALL pass through IDLE for one cycle between them; there is no pipelined issue.

Reset
REQ-023 When rst=1, the following SHALL be forced immediately and asynchronously: state IDLE, counter 0, all WB outputs 0, dmem_req/dmem_we 0, mem_fault 0.
REQ-024 Reset during BUSY SHALL abandon the access without a fault pulse. Operation SHALL resume on the first edge after rst deasserts.

Structure
REQ-025 State encodings and the TIMEOUT default SHALL live in the shared defines file, alongside the existing 16-bit data / 3-bit register width constants.
REQ-026 The MEM/WB output register SHALL be a sub-module named mem_wb_reg, with load-bubble and load-data controls. The FSM and counter SHALL remain in mem_access_stage.

Verification
REQ-027 Reset: assert rst mid-BUSY -> dmem_req=0, wb_* = 0, mem_fault=0 within the same cycle.
REQ-028 ALU pass-through: reg_write=1, alu_result=16'hABCD, write_reg=3'b101, no access -> next edge wb_write_data=16'hABCD, wb_write_reg=5, wb_reg_write=1, mem_stall=0 throughout.
REQ-029 Load: mem_read=1, mem_to_reg=1, addr=16'h0040, memory model returns 16'h1234 with ready on the 3rd BUSY cycle -> dmem_addr=16'h0040 while BUSY; mem_stall high for 3 cycles; wb_write_data=16'h1234.
REQ-030 Store: mem_write=1, addr=16'h0010, data=16'h5A5A, ready immediate -> dmem_we=1 and dmem_wdata=16'h5A5A for exactly one cycle; wb_reg_write=0.
REQ-031 Timeout: load with dmem_ready held 0 -> mem_fault pulses once after 15 BUSY cycles, wb_reg_write=0, FSM in IDLE.
REQ-032 Simultaneous read and write, plus ready while IDLE: mem_read=1 and mem_write=1 -> dmem_we=1 (write wins); a dmem_ready pulse while IDLE causes no state change.
